// File: rtl/hash_arbiter_if.sv
// Hash-side bus between hash_arbiter (master) and the shared hash_mem_interface (slave).
interface hash_arbiter_if #(
    parameter int IO_WIDTH   = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  force_done;
    logic [IO_WIDTH-1:0]   data_in;
    logic [31:0]           input_length;
    logic [31:0]           output_length;
    logic                  data_out_ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd_en;
    logic [IO_WIDTH-1:0]   data_out;
    logic                  data_out_valid;
    logic                  force_done_ack;

    modport master (
        output start, force_done, data_in, input_length, output_length, data_out_ready,
        input  addr, rd_en, data_out, data_out_valid, force_done_ack
    );

    modport slave (
        input  start, force_done, data_in, input_length, output_length, data_out_ready,
        output addr, rd_en, data_out, data_out_valid, force_done_ack
    );
endinterface

// File: rtl/hash_arbiter.sv
// Shares one hash core among N_REQ requesters, one job per grant, held until force-done ack.
// Build option HASH_ARB_FIXED_PRIO_EN: lowest pending index wins instead of round-robin.
module hash_arbiter #(
    parameter int N_REQ      = 4,
    parameter int IO_WIDTH   = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req_start,
    input  logic [N_REQ*IO_WIDTH-1:0] i_req_data_in,
    input  logic [N_REQ*32-1:0]       i_req_input_length,
    input  logic [N_REQ*32-1:0]       i_req_output_length,
    input  logic [N_REQ-1:0]          i_req_data_out_ready,
    input  logic [N_REQ-1:0]          i_req_force_done,
    output logic [ADDR_WIDTH-1:0]     o_req_addr,
    output logic [N_REQ-1:0]          o_req_rd_en,
    output logic [IO_WIDTH-1:0]       o_req_data_out,
    output logic [N_REQ-1:0]          o_req_data_out_valid,
    output logic [N_REQ-1:0]          o_req_force_done_ack,
    output logic [N_REQ-1:0]          o_req_grant,
    hash_arbiter_if.master            hash_if
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   pend_q, pend_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               win_found_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [N_REQ-1:0]   win_oh_s;
    logic               routed_s;
`ifndef HASH_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W:0]     cand_s;
`endif

    // Winner selection among pending requesters
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
`ifdef HASH_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found_s && pend_q[i]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
`else
        cand_s = '0;
        // Search starts just after the previous owner and wraps modulo N_REQ
        for (int i = 1; i <= N_REQ; i++) begin
            cand_s = {1'b0, last_q} + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(N_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && pend_q[cand_s[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
`endif
        win_oh_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (hash_if.force_done_ack) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pending, grant and owner bookkeeping
    always_comb begin
        pend_d  = pend_q | i_req_start;
        grant_d = grant_q;
        owner_d = owner_q;
`ifndef HASH_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        if ((state_q == ST_IDLE) && win_found_s) begin
            pend_d  = pend_d & ~win_oh_s;
            grant_d = win_oh_s;
            owner_d = win_idx_s;
        end else if (state_q == ST_RELEASE) begin
            grant_d = '0;
`ifndef HASH_ARB_FIXED_PRIO_EN
            last_d  = owner_q;
`endif
        end else begin
            grant_d = grant_q;
        end
    end

    // Arbitration registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend_q  <= '0;
            grant_q <= '0;
            owner_q <= '0;
`ifndef HASH_ARB_FIXED_PRIO_EN
            last_q  <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            pend_q  <= pend_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
`ifndef HASH_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign o_req_grant = grant_q;

    // Routing between owner and hash core; everything is quiet outside START/BUSY
    always_comb begin
        routed_s               = (state_q == ST_START) || (state_q == ST_BUSY);
        hash_if.start          = 1'b0;
        hash_if.force_done     = 1'b0;
        hash_if.data_in        = '0;
        hash_if.input_length   = 32'd0;
        hash_if.output_length  = 32'd0;
        hash_if.data_out_ready = 1'b0;
        o_req_addr             = '0;
        o_req_data_out         = '0;
        o_req_rd_en            = '0;
        o_req_data_out_valid   = '0;
        o_req_force_done_ack   = '0;
        if (routed_s) begin
            hash_if.start          = (state_q == ST_START);
            hash_if.force_done     = i_req_force_done[owner_q];
            hash_if.data_in        = i_req_data_in[owner_q*IO_WIDTH +: IO_WIDTH];
            hash_if.input_length   = i_req_input_length[owner_q*32 +: 32];
            hash_if.output_length  = i_req_output_length[owner_q*32 +: 32];
            hash_if.data_out_ready = i_req_data_out_ready[owner_q];
            o_req_addr             = hash_if.addr;
            o_req_data_out         = hash_if.data_out;
            o_req_rd_en            = grant_q & {N_REQ{hash_if.rd_en}};
            o_req_data_out_valid   = grant_q & {N_REQ{hash_if.data_out_valid}};
            if (state_q == ST_BUSY) begin
                o_req_force_done_ack = grant_q & {N_REQ{hash_if.force_done_ack}};
            end else begin
                o_req_force_done_ack = '0;
            end
        end else begin
            o_req_force_done_ack = '0;
        end
    end

endmodule
